keypad_event_decoder: RTL and testbench

KEYPAD_EVENT_DECODER -- requirements
Module: keypad_event_decoder

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/keypad_event_fifo.sv | 58 +++++
 rtl/keypad_event_decoder.sv | 107 ++++++++++
 tb/tb_keypad_event_decoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad matrix constants and event encoding
package keypad_pkg;

    localparam int NUM_KEYS   = 12;
    localparam int KEY_IDX_W  = 4;
    localparam int EVENT_W    = 5;

    // Event layout: {release, index}
    localparam int EV_REL_BIT = 4;
    localparam int EV_IDX_MSB = 3;
    localparam int EV_IDX_LSB = 0;

    typedef logic [EVENT_W-1:0] key_event_t;

    function automatic key_event_t make_event(input logic rel, input logic [KEY_IDX_W-1:0] idx);
        key_event_t ev;
        ev = '0;
        ev[EV_REL_BIT] = rel;
        ev[EV_IDX_MSB:EV_IDX_LSB] = idx;
        return ev;
    endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// rtl/keypad_event_fifo.sv - small event FIFO, write-enable in, valid/ready out
module keypad_event_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic [WIDTH-1:0] rd_tdata,
    output logic             rd_tvalid,
    input  logic             rd_tready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             rd_fire;
    logic             wr_fire;

    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign rd_tvalid = (count != '0);
    assign rd_fire   = rd_tvalid && rd_tready;
    // A write into a full FIFO is legal when the head leaves on the same edge
    assign wr_fire   = wr_en && (!full || rd_fire);
    assign rd_tdata  = rd_tvalid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_event_decoder.sv
// rtl/keypad_event_decoder.sv - debounce 4x3 keypad and queue press/release events
module keypad_event_decoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_in,
    output logic [EVENT_W-1:0]  key_event,
    output logic                key_valid,
    input  logic                key_ready,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                overflow
);

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0]            cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0]   toggle;
    logic [NUM_KEYS-1:0]   pend_press;
    logic [NUM_KEYS-1:0]   pend_release;
    logic [2*NUM_KEYS-1:0] pend;
    logic [2*NUM_KEYS-1:0] pend_set;
    logic [2*NUM_KEYS-1:0] pend_clr;
    logic [2*NUM_KEYS-1:0] sel_onehot;
    key_event_t            sel_event;
    logic                  fifo_full;
    logic                  fifo_wr;

    always_comb begin
        toggle = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            toggle[i] = (keys_in[i] != key_state[i]) && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            key_state <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            key_state <= key_state ^ toggle;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (keys_in[i] == key_state[i] || toggle[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Presses occupy the low half so the lowest-set-bit pick favours them
    assign pend     = {pend_release, pend_press};
    assign pend_set = {toggle & key_state, toggle & ~key_state};

    assign sel_onehot = pend & (~pend + 1'b1);

    always_comb begin
        sel_event = '0;
        for (int i = 2*NUM_KEYS-1; i >= 0; i--) begin
            if (pend[i]) begin
                if (i >= NUM_KEYS) begin
                    sel_event = make_event(1'b1, KEY_IDX_W'(i - NUM_KEYS));
                end else begin
                    sel_event = make_event(1'b0, KEY_IDX_W'(i));
                end
            end
        end
    end

    assign fifo_wr  = (pend != '0) && (!fifo_full || (key_valid && key_ready));
    assign pend_clr = fifo_wr ? sel_onehot : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_press   <= '0;
            pend_release <= '0;
            overflow     <= 1'b0;
        end else begin
            {pend_release, pend_press} <= (pend & ~pend_clr) | pend_set;
            // A bit leaving through the FIFO on this edge frees its slot, so no loss
            if ((pend_set & pend & ~pend_clr) != '0) begin
                overflow <= 1'b1;
            end
        end
    end

    keypad_event_fifo #(
        .WIDTH (EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (fifo_wr),
        .wr_data   (sel_event),
        .full      (fifo_full),
        .rd_tdata  (key_event),
        .rd_tvalid (key_valid),
        .rd_tready (key_ready)
    );

endmodule

// File: tb/tb_keypad_event_decoder.sv
// tb/tb_keypad_event_decoder.sv - directed self-checking bench for keypad_event_decoder
module tb_keypad_event_decoder;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] keys_in;
    logic [4:0]  key_event;
    logic        key_valid;
    logic        key_ready;
    logic [11:0] key_state;
    logic        overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    keypad_event_decoder #(
        .DEBOUNCE_CYCLES (8),
        .FIFO_DEPTH      (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .keys_in   (keys_in),
        .key_event (key_event),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_state (key_state),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        keys_in   = '0;
        key_ready = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [4:0] ev);
        check({tag, "_valid"}, 32'(key_valid), 32'd1);
        check({tag, "_event"}, 32'(key_event), 32'(ev));
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        keys_in   = '0;
        key_ready = 1'b0;
        tick(2);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_event", 32'(key_event), 32'd0);
        check("rst_state", 32'(key_state), 32'd0);
        check("rst_ovf",   32'(overflow),  32'd0);
        reset = 1'b0;

        // single press: state at edge 8, event at edge 9, consumed at edge 10
        keys_in   = 12'h001;
        key_ready = 1'b1;
        tick(7);
        check("p0_state_e7", 32'(key_state), 32'h000);
        tick();
        check("p0_state_e8", 32'(key_state), 32'h001);
        check("p0_valid_e8", 32'(key_valid), 32'd0);
        tick();
        check("p0_valid_e9", 32'(key_valid), 32'd1);
        check("p0_event_e9", 32'(key_event), 32'h00);
        tick();
        check("p0_valid_e10", 32'(key_valid), 32'd0);
        keys_in = 12'h000;
        tick(8);
        check("r0_state", 32'(key_state), 32'h000);
        tick();
        check("r0_valid", 32'(key_valid), 32'd1);
        check("r0_event", 32'(key_event), 32'h10);
        tick();
        check("r0_drained", 32'(key_valid), 32'd0);

        // glitch one cycle short of acceptance
        do_reset();
        keys_in = 12'h020;
        tick(7);
        keys_in = 12'h000;
        tick(10);
        check("gl_state", 32'(key_state), 32'h000);
        check("gl_valid", 32'(key_valid), 32'd0);
        check("gl_ovf",   32'(overflow),  32'd0);

        // two keys together, consumer stalled
        do_reset();
        keys_in = 12'h0A0;
        tick(12);
        check("k57_state", 32'(key_state), 32'h0A0);
        check("k57_head",  32'(key_event), 32'h05);
        keys_in = 12'h000;
        tick(12);
        check("k57_head_stable", 32'(key_event), 32'h05);
        key_ready = 1'b1;
        expect_head("k57_d0", 5'h05);
        expect_head("k57_d1", 5'h07);
        expect_head("k57_d2", 5'h15);
        expect_head("k57_d3", 5'h17);
        check("k57_empty", 32'(key_valid), 32'd0);

        // six events into a four-entry FIFO, then drain through the wrap
        do_reset();
        keys_in = 12'h007;
        tick(12);
        keys_in = 12'h000;
        tick(12);
        check("six_ovf",  32'(overflow),  32'd0);
        check("six_head", 32'(key_event), 32'h00);
        key_ready = 1'b1;
        expect_head("six_d0", 5'h00);
        expect_head("six_d1", 5'h01);
        expect_head("six_d2", 5'h02);
        expect_head("six_d3", 5'h10);
        expect_head("six_d4", 5'h11);
        expect_head("six_d5", 5'h12);
        check("six_empty", 32'(key_valid), 32'd0);

        // repeated press of key 3 while its press is still pending
        do_reset();
        keys_in = 12'h003;
        tick(11);
        keys_in = 12'h000;
        tick(11);
        keys_in = 12'h008;
        tick(9);
        check("ovf_after_press1", 32'(overflow), 32'd0);
        keys_in = 12'h000;
        tick(9);
        check("ovf_after_release", 32'(overflow), 32'd0);
        keys_in = 12'h008;
        tick(9);
        check("ovf_after_press2", 32'(overflow),  32'd1);
        check("ovf_state",        32'(key_state), 32'h008);
        key_ready = 1'b1;
        expect_head("ovf_d0", 5'h00);
        expect_head("ovf_d1", 5'h01);
        expect_head("ovf_d2", 5'h10);
        expect_head("ovf_d3", 5'h11);
        expect_head("ovf_d4", 5'h03);
        expect_head("ovf_d5", 5'h13);
        check("ovf_empty",  32'(key_valid), 32'd0);
        check("ovf_sticky", 32'(overflow),  32'd1);

        // reset with queued events while key 9 stays held
        key_ready = 1'b0;
        keys_in   = 12'h203;
        tick(12);
        check("mid_queued", 32'(key_valid), 32'd1);
        check("mid_head",   32'(key_event), 32'h00);
        keys_in = 12'h200;
        reset   = 1'b1;
        tick();
        check("mid_rst_valid", 32'(key_valid), 32'd0);
        check("mid_rst_state", 32'(key_state), 32'h000);
        check("mid_rst_ovf",   32'(overflow),  32'd0);
        reset = 1'b0;
        tick(8);
        check("k9_state_e8", 32'(key_state), 32'h200);
        check("k9_valid_e8", 32'(key_valid), 32'd0);
        tick();
        check("k9_valid_e9", 32'(key_valid), 32'd1);
        check("k9_event_e9", 32'(key_event), 32'h09);
        tick(3);
        check("k9_stable", 32'(key_event), 32'h09);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
